// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the single-cycle ALU result stream and the
// buffered load-response stream into one registered register-file write
// port. It also keeps the pending-load scoreboard and raises alu_stall when
// the load FIFO head has been starved by ALU writes for too long.
module writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic [31:0] busy,
  output logic        alu_stall,
  output logic        wr_en,
  output logic [4:0]  wr_idx,
  output logic [31:0] wr_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  logic [4:0]    mem_idx_q  [DEPTH];
  logic [4:0]    mem_idx_d  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          alu_stall_q, alu_stall_d;
  logic [31:0]   busy_q, busy_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_idx_q, wr_idx_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic alu_req;
  logic fifo_nonempty;
  logic push;
  logic pop;
  logic [SW-1:0] starve_inc;

  // Request decode: x0 destinations never become writes or FIFO entries.
  always_comb begin
    ld_ready      = rst & (count_q < DEPTH_C);
    alu_req       = alu_valid & (alu_rd != 5'd0);
    fifo_nonempty = (count_q != '0);
    push          = ld_valid & ld_ready & (ld_rd != 5'd0);
    pop           = ~alu_req & fifo_nonempty;
    starve_inc    = starve_q + SW'(1);
  end

  // FIFO storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    mem_idx_d  = mem_idx_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (push) begin
      mem_idx_d[tail_q]  = ld_rd;
      mem_data_d[tail_q] = ld_data;
      tail_d             = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Write-port selection: ALU first, then the FIFO head, else hold idx/data.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (alu_req) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = alu_rd;
      wr_data_d = alu_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = mem_idx_q[head_q];
      wr_data_d = mem_data_q[head_q];
    end
  end

  // Scoreboard: a pop clears its destination, a new issue sets one (set wins).
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[mem_idx_q[head_q]] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter: counts ALU wins over a waiting head, pulses alu_stall.
  always_comb begin
    starve_d    = starve_q;
    alu_stall_d = 1'b0;
    if (!fifo_nonempty || pop) begin
      starve_d = '0;
    end else if (alu_req) begin
      if (starve_inc == STARVE_C) begin
        starve_d    = '0;
        alu_stall_d = 1'b1;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  // State registers; reset discards queued loads and pending busy bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      busy_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      mem_idx_q   <= mem_idx_d;
      mem_data_q  <= mem_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign alu_stall = alu_stall_q;
  assign wr_en     = wr_en_q;
  assign wr_idx    = wr_idx_q;
  assign wr_data   = wr_data_q;

endmodule
